delay_sum_sequencer: RTL and testbench

//  Sequences the delay-and-sum stage: streams NUM_CH aligned channel samples per output index from

---
 rtl/filter_pkg.sv | 20 ++
 rtl/rd_valid_pipe.sv | 34 +++
 rtl/delay_sum_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_delay_sum_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Constants and types shared by the delay-and-sum datapath, the controller, the indexing stage
// and the communication block.
package filter_pkg;

  localparam int unsigned NUM_CH    = 8;
  localparam int unsigned NUM_SAMP  = 768;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SUM_W     = 40;
  localparam int unsigned RD_ADDR_W = 13;
  localparam int unsigned WR_ADDR_W = 10;
  localparam int unsigned RD_LAT    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } dss_state_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// Delays the read-issue strobe and its last-channel tag so that they line up with the data
// coming back from output_ram.
module rd_valid_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] last_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      last_q[0]  <= last_i;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign last_o  = last_q[Depth-1];

endmodule

// File: rtl/delay_sum_sequencer.sv
// Streams NumCh aligned samples per output index out of output_ram, accumulates them one read per
// cycle and writes one sum per index to sum_ram.
module delay_sum_sequencer
  import filter_pkg::*;
#(
  parameter int unsigned NumCh   = NUM_CH,
  parameter int unsigned NumSamp = NUM_SAMP,
  parameter int unsigned DataW   = DATA_W,
  parameter int unsigned SumW    = SUM_W,
  parameter int unsigned RdAddrW = RD_ADDR_W,
  parameter int unsigned WrAddrW = WR_ADDR_W,
  parameter int unsigned RdLat   = RD_LAT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               rd_en_o,
  output logic [RdAddrW-1:0] rd_addr_o,
  input  logic [DataW-1:0]   rd_data_i,
  output logic               wr_en_o,
  output logic [WrAddrW-1:0] wr_addr_o,
  output logic [SumW-1:0]    wr_data_o
);

  localparam int unsigned ChW = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam logic [ChW-1:0]     ChLast = ChW'(NumCh - 1);
  localparam logic [WrAddrW-1:0] TLast  = WrAddrW'(NumSamp - 1);
  localparam logic [RdAddrW-1:0] Step   = RdAddrW'(NumSamp);

  dss_state_t state_q, state_d;
  logic [ChW-1:0]     ch_q, ch_d;
  logic [WrAddrW-1:0] t_q, t_d;
  logic [RdAddrW-1:0] base_q, base_d;
  logic [RdAddrW-1:0] rd_addr_q, rd_addr_d;
  logic               rd_en_q, rd_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SumW-1:0]    acc_q, acc_d;
  logic               first_q, first_d;
  logic               wr_pend_q, wr_pend_d;
  logic               wr_en_q, wr_en_d;
  logic [WrAddrW-1:0] wr_addr_q, wr_addr_d;
  logic [SumW-1:0]    wr_data_q, wr_data_d;
  logic [WrAddrW-1:0] t_out_q, t_out_d;

  logic            accept;
  logic            pipe_valid;
  logic            pipe_last;
  logic [SumW-1:0] sample;

  assign accept = (state_q == StIdle) && start_i;
  assign sample = {{(SumW - DataW){rd_data_i[DataW-1]}}, rd_data_i};

  rd_valid_pipe #(
    .Depth (RdLat)
  ) u_rd_valid_pipe (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (rd_en_q),
    .last_i  (ch_q == ChLast),
    .valid_o (pipe_valid),
    .last_o  (pipe_last)
  );

  // Issue side: the address is a running base plus t, so no multiplier is needed.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    t_d       = t_q;
    base_d    = base_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StIssue;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          ch_d      = '0;
          t_d       = '0;
          base_d    = '0;
          rd_addr_d = '0;
        end
      end
      StIssue: begin
        if (ch_q == ChLast && t_q == TLast) begin
          state_d = StDrain;
        end else begin
          rd_en_d = 1'b1;
          if (ch_q == ChLast) begin
            ch_d   = '0;
            t_d    = t_q + 1'b1;
            base_d = '0;
          end else begin
            ch_d   = ch_q + 1'b1;
            base_d = base_q + Step;
          end
          rd_addr_d = base_d + RdAddrW'(t_d);
        end
      end
      StDrain: begin
        if (wr_en_q && wr_addr_q == TLast && !pipe_valid) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Return side: one stage to close the sum, one stage to register the sum_ram write.
  always_comb begin
    acc_d     = acc_q;
    first_d   = first_q;
    wr_pend_d = pipe_valid & pipe_last;
    wr_en_d   = wr_pend_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    t_out_d   = accept ? '0 : t_out_q;
    if (pipe_valid) begin
      acc_d   = first_q ? sample : acc_q + sample;
      first_d = pipe_last;
    end
    if (wr_pend_q) begin
      wr_addr_d = t_out_q;
      wr_data_d = acc_q;
      t_out_d   = t_out_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      t_q       <= '0;
      base_q    <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      first_q   <= 1'b1;
      wr_pend_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      t_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      t_q       <= t_d;
      base_q    <= base_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      wr_pend_q <= wr_pend_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      t_out_q   <= t_out_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_delay_sum_sequencer.sv
// Self-checking bench for delay_sum_sequencer: a behavioural output_ram, a scoreboard of expected
// sums and a table of data patterns, plus ignored-start and mid-pass reset sequences.
module tb_delay_sum_sequencer;
  import filter_pkg::*;

  localparam int NCh        = NUM_CH;
  localparam int NS         = NUM_SAMP;
  localparam int FirstWrLat = 1 + NUM_CH + RD_LAT + 1;
  localparam int DoneLat    = NUM_CH * NUM_SAMP + RD_LAT + 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 busy, done, rd_en, wr_en;
  logic [RD_ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]    rd_data = '0;
  logic [WR_ADDR_W-1:0] wr_addr;
  logic [SUM_W-1:0]     wr_data;

  delay_sum_sequencer dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode_g = 0;
  logic [SUM_W-1:0] sb_q[$];

  function automatic logic [DATA_W-1:0] word(input int mode, input int a);
    logic [31:0] x;
    x = a;
    case (mode)
      0:       return DATA_W'(a / NS + a % NS);
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      default: return (x * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic [SUM_W-1:0] model_sum(input int mode, input int t);
    logic [SUM_W-1:0]  s;
    logic [DATA_W-1:0] w;
    s = '0;
    for (int c = 0; c < NCh; c++) begin
      w = word(mode, c * NS + t);
      s = s + {{(SUM_W - DATA_W){w[DATA_W-1]}}, w};
    end
    return s;
  endfunction

  // output_ram: address registered on the edge, data two edges after the read strobe
  logic [RD_ADDR_W-1:0] ra_q = '0;
  always @(posedge clk) begin
    ra_q    <= rd_addr;
    rd_data <= word(mode_g, int'(ra_q));
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_pass(input string name, input int mode, input int ign_a, input int ign_b,
                          input int rst_at, input bit has_const,
                          input logic [SUM_W-1:0] exp_first, input logic [SUM_W-1:0] exp_last);
    int rel, first_wr, done_rel, n_wr, n_done, n_rd, rd_first, rd_last, rd_bad, late, exp_ra;
    logic [SUM_W-1:0] first_data, last_data, exp;
    bit fin;
    sb_q.delete();
    for (int t = 0; t < NS; t++) sb_q.push_back(model_sum(mode, t));
    mode_g   = mode;
    first_wr = -1;
    done_rel = -1;
    n_wr     = 0;
    n_done   = 0;
    n_rd     = 0;
    rd_first = -1;
    rd_last  = -1;
    rd_bad   = 0;
    late     = 0;
    first_data = '0;
    last_data  = '0;
    fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    rel = 0;
    while (!fin) begin
      @(negedge clk);
      rel++;
      if (rst_at > 0 && rel == rst_at + 1) begin
        check({busy, done, rd_en, wr_en} == 4'b0 && rd_addr == '0 && wr_addr == '0 &&
              wr_data == '0, {name, "_reset_outputs"},
              {4'b0, busy, done, rd_en, wr_en, 3'b0, rd_addr, 6'b0, wr_addr, wr_data}, 64'h0);
      end
      if (rst_at > 0 && rel > rst_at) begin
        if (wr_en || done || busy || rd_en) late++;
      end else begin
        if (rel == 1) check(busy && rd_en && rd_addr == '0, {name, "_issue_start"},
                            {busy, rd_en, rd_addr}, {2'b11, 13'h0});
        if (rd_en) begin
          exp_ra = (n_rd % NCh) * NS + n_rd / NCh;
          if (int'(rd_addr) != exp_ra) rd_bad++;
          if (rd_first < 0) rd_first = rel;
          rd_last = rel;
          n_rd++;
        end
        if (wr_en) begin
          if (first_wr < 0) begin
            first_wr   = rel;
            first_data = wr_data;
          end
          last_data = wr_data;
          if (sb_q.size() == 0) begin
            check(1'b0, {name, "_extra_write"}, 64'(wr_addr), 64'(NS));
          end else begin
            exp = sb_q.pop_front();
            check(int'(wr_addr) == n_wr, {name, "_wr_addr"}, 64'(wr_addr), 64'(n_wr));
            check(wr_data == exp, {name, "_wr_data"}, 64'(wr_data), 64'(exp));
          end
          n_wr++;
        end
        if (done) begin
          n_done++;
          if (done_rel < 0) done_rel = rel;
          check(!busy, {name, "_busy_at_done"}, 64'(busy), 64'h0);
        end
      end
      start = (rel == ign_a || rel == ign_b);
      reset = (rst_at > 0 && rel == rst_at);
      if (rst_at > 0 && rel >= rst_at + 100) fin = 1'b1;
      if (rst_at == 0 && done_rel >= 0 && rel >= done_rel + 3) fin = 1'b1;
      if (!fin && rel >= DoneLat + 200) begin
        check(1'b0, {name, "_timeout"}, 64'(rel), 64'(DoneLat));
        fin = 1'b1;
      end
    end
    start = 1'b0;
    reset = 1'b0;
    if (rst_at > 0) begin
      check(late == 0, {name, "_activity_after_reset"}, 64'(late), 64'h0);
    end else begin
      check(first_wr == FirstWrLat, {name, "_first_wr_latency"}, 64'(first_wr), 64'(FirstWrLat));
      check(done_rel == DoneLat, {name, "_done_latency"}, 64'(done_rel), 64'(DoneLat));
      check(n_wr == NS, {name, "_write_count"}, 64'(n_wr), 64'(NS));
      check(n_done == 1, {name, "_done_count"}, 64'(n_done), 64'h1);
      check(n_rd == NCh * NS && rd_last - rd_first + 1 == n_rd, {name, "_rd_contiguous"},
            64'(rd_last - rd_first + 1), 64'(NCh * NS));
      check(rd_bad == 0, {name, "_rd_addr_seq"}, 64'(rd_bad), 64'h0);
      if (has_const) begin
        check(first_data == exp_first, {name, "_sum_t0"}, 64'(first_data), 64'(exp_first));
        check(last_data == exp_last, {name, "_sum_tlast"}, 64'(last_data), 64'(exp_last));
      end
    end
  endtask

  typedef struct {
    int               mode;
    logic [SUM_W-1:0] exp_first;
    logic [SUM_W-1:0] exp_last;
    bit               has_const;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{mode: 0, exp_first: 40'd28, exp_last: 40'd6164, has_const: 1'b1};
    vecs[1] = '{mode: 1, exp_first: 40'hFF_FFFF_FFF8, exp_last: 40'hFF_FFFF_FFF8, has_const: 1'b1};
    vecs[2] = '{mode: 2, exp_first: 40'h03_FFFF_FFF8, exp_last: 40'h03_FFFF_FFF8, has_const: 1'b1};
    vecs[3] = '{mode: 3, exp_first: '0, exp_last: '0, has_const: 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check({busy, done, rd_en, wr_en} == 4'b0 && rd_addr == '0 && wr_addr == '0 &&
          wr_data == '0, "reset_state", {busy, done, rd_en, wr_en}, 64'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check(!busy && !rd_en, "idle_without_start", {busy, rd_en}, 64'h0);

    for (int i = 0; i < 4; i++) begin
      run_pass($sformatf("vec%0d", i), vecs[i].mode, -1, -1, 0, vecs[i].has_const,
               vecs[i].exp_first, vecs[i].exp_last);
    end
    run_pass("ignored_start", 0, 100, 5000, 0, 1'b1, 40'd28, 40'd6164);
    run_pass("reset_mid", 3, -1, -1, 3000, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    run_pass("after_reset", 0, -1, -1, 0, 1'b1, 40'd28, 40'd6164);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
